regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 64: register data width in bits.
REQ-002 Parameter NREG, default 32, power of two: register count; AW = log2(NREG).
REQ-003 Parameter NRD, default 2: number of read ports.
REQ-004 Parameter NWR, default 2: number of write ports.
REQ-005 Parameter BYPASS, default 1: 1 forwards same-cycle write data to reads, 0 disables forwarding.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 rd_addr_i  in  NRD*AW  read addresses; port p occupies bits [p*AW +: AW].
REQ-009 rd_data_o  out  NRD*XLEN  read data per port, combinational.
REQ-010 rd_busy_o  out  NRD  per-port scoreboard status: register has an outstanding producer.
REQ-011 wr_en_i  in  NWR  per-port write enable.
REQ-012 wr_addr_i  in  NWR*AW  write addresses.
REQ-013 wr_data_i  in  NWR*XLEN  write data.
REQ-014 alloc_en_i  in  1  mark destination register busy (issue of a producer).
REQ-015 alloc_addr_i  in  AW  register to mark busy.
REQ-016 busy_cnt_o  out  AW+1  registered count of busy registers.

Function
REQ-017 Register 0 SHALL read as zero, SHALL never be written, SHALL never be busy; writes/allocs to 0 are ignored.
REQ-018 On a clock edge with rst_n high, each port w with wr_en_i[w]=1 and nonzero address SHALL update that register with its data.
REQ-019 When several write ports target the same register in one cycle, the highest-indexed port SHALL win, for both storage and bypass.
REQ-020 Read port p SHALL return stored contents of rd_addr_i[p] in the same cycle (zero latency).
REQ-021 With BYPASS=1 and rst_n high, if any enabled write port targets the read address (nonzero), rd_data_o SHALL equal the winning port's write data.
REQ-022 With BYPASS=0, reads SHALL return pre-edge stored contents; new data visible the cycle after the write.
REQ-023 Busy bit SHALL set on an edge with alloc_en_i=1 (nonzero alloc_addr_i) and clear on an edge where any enabled write targets that register.
REQ-024 Alloc and write to the same register in the same cycle: write data SHALL be stored and busy bit SHALL end set (new producer wins).
REQ-025 rd_busy_o[p] SHALL equal the stored busy bit of rd_addr_i[p]; with BYPASS=1 it SHALL read 0 when an enabled write targets that register in the same cycle.
REQ-026 rd_busy_o SHALL not reflect a same-cycle alloc (alloc takes effect after the edge).
REQ-027 busy_cnt_o SHALL equal the population count of busy bits after each edge, range 0..NREG-1.
REQ-028 Widths SHALL be exact; no sign extension or truncation of data.

Reset
REQ-029 On an edge with rst_n low, all registers SHALL clear to zero, all busy bits to 0, busy_cnt_o to 0; writes and allocs that cycle are discarded.
REQ-030 While rst_n is low, bypass SHALL be suppressed and rd_busy_o SHALL reflect stored state only.
REQ-031 Reset asserted mid-operation SHALL take effect at the next edge regardless of pending allocs.

Verification
REQ-032 Reset, then read all 32 addresses on both ports -> rd_data_o=0, rd_busy_o=0, busy_cnt_o=0.
REQ-033 Write port0 x5=0x1234, same cycle read x5 -> BYPASS=1: 0x1234 that cycle; BYPASS=0: 0 that cycle, 0x1234 next cycle.
REQ-034 Port0 and port1 write x7 with 0xAAAA and 0x5555 same cycle -> read x7 = 0x5555 both during (bypass) and after.
REQ-035 Alloc x3 -> next cycle rd_busy=1, busy_cnt_o=1; write x3=0xBEEF -> busy clears after edge, busy_cnt_o=0; alloc+write x3 same cycle -> data 0xBEEF stored, busy stays 1.
REQ-036 Write x0=0xFFFF and alloc x0 -> read x0=0, rd_busy=0, busy_cnt_o unchanged.
REQ-037 Alloc x1,x2,x4 then assert rst_n low one cycle with a write to x1 -> all registers 0, busy_cnt_o=0, x1 reads 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-ported register file with an integrated busy scoreboard.
// Register 0 is hardwired to zero and can never become busy.
// Reads are combinational. With BYPASS set, a read sees the data being
// written in the same cycle, and that register's busy bit reads as clear.
module regfile_sb #(
  parameter  int unsigned XLEN   = 64,
  parameter  int unsigned NREG   = 32,
  parameter  int unsigned NRD    = 2,
  parameter  int unsigned NWR    = 2,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                alloc_en_i,
  input  logic [AW-1:0]       alloc_addr_i,
  output logic [AW:0]         busy_cnt_o
);

  logic [XLEN-1:0] regs   [NREG];
  logic [XLEN-1:0] wr_val [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] wr_hit;
  logic [NREG-1:0] alloc_mask;
  logic [AW:0]     cnt_nxt;

  // Decode write ports per register; later ports overwrite earlier ones so the highest index wins
  always_comb begin
    wr_hit = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      wr_val[r] = '0;
    end
    for (int unsigned w = 0; w < NWR; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
        wr_hit[wr_addr_i[w*AW +: AW]] = 1'b1;
        wr_val[wr_addr_i[w*AW +: AW]] = wr_data_i[w*XLEN +: XLEN];
      end
    end
  end

  // Next busy vector: writes retire producers, and an alloc in the same cycle sets the bit again
  always_comb begin
    alloc_mask = '0;
    if (alloc_en_i && (alloc_addr_i != '0)) begin
      alloc_mask[alloc_addr_i] = 1'b1;
    end
    busy_nxt = (busy & ~wr_hit) | alloc_mask;
    cnt_nxt  = (AW+1)'($countones(busy_nxt));
  end

  // Zero-latency read ports, with optional forwarding of same-cycle write data
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      rd_data_o[p*XLEN +: XLEN] = regs[rd_addr_i[p*AW +: AW]];
      rd_busy_o[p]              = busy[rd_addr_i[p*AW +: AW]];
      if ((BYPASS != 0) && rst_n && wr_hit[rd_addr_i[p*AW +: AW]]) begin
        rd_data_o[p*XLEN +: XLEN] = wr_val[rd_addr_i[p*AW +: AW]];
        rd_busy_o[p]              = 1'b0;
      end
    end
  end

  // Storage, busy bits and busy count; reset discards any write or alloc in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
      busy       <= '0;
      busy_cnt_o <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
      end
      busy       <= busy_nxt;
      busy_cnt_o <= cnt_nxt;
    end
  end

endmodule
